apb_slave_regfile: RTL
======================

APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 SHALL have parameter SEL_BIT, default 0: index of the Pselx bit that selects this slave (0..2).
REQ-002 SHALL have parameter WAIT_STATES, default 0: access-phase wait cycles inserted before Pready (0..7).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h8000_0000: only BASE_ADDR[31:6] is compared.
REQ-004 SHALL have parameter ID_VALUE, default 32'hA5B0_0001: read-only contents of word 0.
REQ-005 SHALL have port Hclk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port Hresetn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port Pselx  input  3  APB selects; only Pselx[SEL_BIT] is used (sel).
REQ-008 SHALL have port Penable  input  1  APB access-phase indicator.
REQ-009 SHALL have port Pwrite  input  1  1 = write, 0 = read.
REQ-010 SHALL have port Paddr  input  32  byte address.
REQ-011 SHALL have port Pwdata  input  32  write data.
REQ-012 SHALL have port Prdata  output  32  read data.
REQ-013 SHALL have port Pready  output  1  transfer-complete strobe.
REQ-014 SHALL have port Pslverr  output  1  error response, qualified by Pready.

Function
REQ-015 SHALL hold 16 x 32-bit words indexed by Paddr[5:2]; word 0 reads ID_VALUE, words 1..15 are read/write storage.
REQ-016 SHALL implement FSM IDLE, ACCESS; IDLE -> ACCESS on the edge where sel=1 and Penable=0 (setup phase).
REQ-017 SHALL capture Paddr, Pwrite, Pwdata and load wait counter = WAIT_STATES on the IDLE->ACCESS edge; input changes during ACCESS are ignored.
REQ-018 SHALL, in ACCESS with sel=1 and Penable=1, decrement the wait counter each cycle while it is non-zero; hold the counter when Penable=0.
REQ-019 SHALL drive Pready=1 combinationally only when state=ACCESS, sel=1, Penable=1 and counter=0; WAIT_STATES=0 gives Pready in the first access cycle.
REQ-020 SHALL complete the transfer on the edge where Pready=1, returning to IDLE; back-to-back setup is accepted on the following cycle.
REQ-021 SHALL commit a captured write to its word on the completion edge only, and only when no error is flagged.
REQ-022 SHALL flag an error when captured Paddr[31:6] != BASE_ADDR[31:6], Paddr[1:0] != 0, or a write targets word 0.
REQ-023 SHALL drive Pslverr = error flag while Pready=1 in ACCESS; Pslverr SHALL be 0 at all other times.
REQ-024 SHALL drive Prdata = selected word only while Pready=1 for a non-errored read; otherwise Prdata SHALL be 0.
REQ-025 SHALL abort with no write and return to IDLE when sel drops in ACCESS before completion.
REQ-026 SHALL, in IDLE with sel=1 and Penable=1 (no setup seen), drive Pready=1 and Pslverr=1 for that cycle, with no state change and no write.
REQ-027 SHALL ignore all inputs when sel=0 in IDLE; Pready=0, Pslverr=0, Prdata=0.

Reset
REQ-028 SHALL, on Hresetn=0, immediately force state=IDLE, counter=0, words 1..15=0, captured address/data/write=0.
REQ-029 SHALL have outputs Prdata=0, Pready=0 and Pslverr=0 while in reset.
REQ-030 SHALL abort an in-flight transfer on reset with no write committed; the first setup after reset release is accepted.

Verification
REQ-031 SHALL pass test: WAIT_STATES=0, write 32'hDEAD_BEEF to 32'h8000_0008, then read the same address -> write Pready in first access cycle, Pslverr=0; read Prdata=32'hDEAD_BEEF.
REQ-032 SHALL pass test: WAIT_STATES=3, read 32'h8000_0000 -> Pready low for 3 access cycles, high on the 4th with Prdata=32'hA5B0_0001.
REQ-033 SHALL pass test: write 32'h1 to 32'h8000_0000, 32'h9000_0004 and 32'h8000_0006 -> each completes with Pslverr=1; a read of 32'h8000_0004 afterwards returns 0.
REQ-034 SHALL pass test: WAIT_STATES=2, write to 32'h8000_000C, drop sel after 1 access cycle, then read 32'h8000_000C -> no Pready on the aborted transfer; read returns 0.
REQ-035 SHALL pass test: assert Hresetn=0 mid-wait of a write, then release -> outputs 0 immediately, word unchanged, next setup accepted.
REQ-036 SHALL pass test: Pselx[SEL_BIT]=1 and Penable=1 with no setup cycle -> Pready=1, Pslverr=1 for one cycle, storage unchanged.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB slave with a 16-word register file: word 0 is a read-only ID, words 1..15 are storage.
// Supports configurable access-phase wait states and a PSLVERR response for bad accesses.
module apb_slave_regfile #(
  parameter int unsigned SEL_BIT     = 0,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic [1:0] SEL_IDX  = 2'(SEL_BIT);
  localparam logic [2:0] WAIT_INI = 3'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [31:0] mem_q [16];

  logic        sel_s;
  logic [3:0]  idx_s;
  logic        err_s;
  logic        done_s;
  logic        bad_idle_s;
  logic        commit_s;
  logic [31:0] rd_word_s;

  assign sel_s      = Pselx[SEL_IDX];
  assign idx_s      = addr_q[5:2];
  // All checks use the captured transfer, never the live bus.
  assign err_s      = (addr_q[31:6] != BASE_ADDR[31:6]) || (addr_q[1:0] != 2'b00) ||
                      (write_q && (idx_s == 4'd0));
  assign done_s     = (state_q == ACCESS) && sel_s && Penable && (cnt_q == 3'd0);
  assign bad_idle_s = (state_q == IDLE) && sel_s && Penable;
  assign commit_s   = done_s && write_q && !err_s;
  assign rd_word_s  = (idx_s == 4'd0) ? ID_VALUE : mem_q[idx_s];

  // State, wait counter and captured transfer registers.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  // Next-state logic: capture on setup, count down while enabled, leave on completion or sel drop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    case (state_q)
      IDLE: begin
        if (sel_s && !Penable) begin
          state_d = ACCESS;
          cnt_d   = WAIT_INI;
          addr_d  = Paddr;
          wdata_d = Pwdata;
          write_d = Pwrite;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!sel_s) begin
          state_d = IDLE;
        end else if (Penable) begin
          if (cnt_q == 3'd0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end else begin
          state_d = ACCESS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register file storage; word 0 is never written because such writes are flagged as errors.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (commit_s) begin
      mem_q[idx_s] <= wdata_q;
    end else begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= mem_q[i];
      end
    end
  end

  // Bus responses are combinational and forced low while reset is asserted.
  always_comb begin
    Pready  = 1'b0;
    Pslverr = 1'b0;
    Prdata  = 32'd0;
    if (Hresetn) begin
      Pready  = done_s || bad_idle_s;
      Pslverr = (done_s && err_s) || bad_idle_s;
      if (done_s && !write_q && !err_s) begin
        Prdata = rd_word_s;
      end else begin
        Prdata = 32'd0;
      end
    end else begin
      Pready  = 1'b0;
      Pslverr = 1'b0;
      Prdata  = 32'd0;
    end
  end

endmodule
